icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//   Direct-mapped, one-word-per-frame instruction cache between the datapath fetch port and the memory controller.
//   Serves the datapath's instruction requests and answers hits in the same cycle.
//   On a miss it fetches the word from memory and fills the frame.
//   Holds the datapath in stall (ihit=0) until the requested word is present.
// PARAMETERS
//   SETS     16   number of frames; power of two, >=2; IDX_W = log2(SETS)
// PORTS
//   CLK        in   1    clock; all state updates on rising edge
//   RST        in   1    reset, synchronous, active-high
//   imemREN    in   1    datapath instruction read request
//   imemaddr   in   32   datapath instruction byte address; bits [1:0] ignored
//   ihit       out  1    requested word valid on imemload this cycle
//   imemload   out  32   instruction word
//   iREN       out  1    memory read request
//   iaddr      out  32   memory word address, bits [1:0] always 0
//   iwait      in   1    memory busy; iload valid in any cycle with iREN=1 and iwait=0
//   iload      in   32   memory read data
//   flush      in   1    invalidate all frames (driven at halt and on self-modifying-code events)
// BEHAVIOUR
//   Address split:
//     idx = imemaddr[IDX_W+1:2]
//     tag = imemaddr[31:IDX_W+2]
//   Storage per frame: valid bit, tag, 32-bit data.
//     Data and tag are not reset; only the valid bits are reset.
//   hit = (state==IDLE) && imemREN && valid[idx] && tag_arr[idx]==tag && !flush.
//   ihit = hit, combinational, zero-cycle latency.
//   imemload = data[idx] when hit, else 32'h0.
//   FSM states: IDLE, FILL.
//   IDLE:
//     iREN = 0; iaddr = 32'h0.
//     imemREN && !hit && !flush -> FILL.
//     On that edge, latch miss_addr = {imemaddr[31:2], 2'b00}.
//   FILL:
//     iREN = 1; iaddr = miss_addr; ihit = 0.
//     While iwait=1: stay in FILL.
//     On iwait=0: write data = iload, write tag and set valid for miss_addr's idx, then -> IDLE.
//     Next cycle the same request hits.
//   Miss penalty: 1 cycle + memory wait cycles, then 1 hit cycle.
//   Request change mid-fill: the fill still completes for the latched address.
//     If imemREN drops or imemaddr changes during FILL, there is no abort.
//     The new request is evaluated in IDLE afterwards.
//   flush:
//     Clears every valid bit at the clock edge and forces ihit=0 in that cycle.
//     In IDLE: flush blocks the IDLE->FILL transition.
//     In FILL: the memory transaction still completes, but the valid bit is not set.
//       Flush wins over fill completion; the frame stays invalid.
//   Reset:
//     All valid bits = 0, state = IDLE, miss_addr = 0.
//     Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
//     Reset during FILL drops iREN in the cycle after the reset edge.
//   Conflict miss: a miss to the same idx with a different tag overwrites the old frame.
// CONFIGURATION
//   ICACHE_STATS_EN defined:
//     Adds output ports hit_count[31:0] and miss_count[31:0].
//     hit_count increments on every cycle with ihit=1.
//     miss_count increments on every IDLE->FILL transition.
//     Both counters saturate at 32'hFFFF_FFFF, reset to 0, and are not cleared by flush.
//   ICACHE_STATS_EN undefined:
//     No counter logic and no counter ports; all other behaviour is identical.
// TESTING
//   1. Cold miss:
//      After reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles, then iload=0x2001_0005.
//      -> iREN=1, iaddr=0x40 for 4 cycles, ihit=0 throughout.
//      -> Next cycle ihit=1, imemload=0x2001_0005.
//   2. Hit:
//      Repeat 0x40; also 0x42 (byte bits ignored).
//      -> ihit=1 in the same cycle, iREN=0, no memory traffic.
//   3. Conflict:
//      Fill 0x40, then access 0x80 (SETS=16, same idx).
//      -> miss, then 0x80 hits.
//      -> 0x40 then misses again.
//   4. Flush:
//      Fill 0x40, then assert flush for 1 cycle with imemREN=1 @0x40.
//      -> ihit=0 in that cycle; the next access to 0x40 misses.
//      -> Flush on the same edge as iwait falling: the frame stays invalid.
//   5. Address change mid-fill:
//      Miss @0x40; during FILL switch to 0x44.
//      -> iaddr stays 0x40 until fill completes.
//      -> Then a miss for 0x44; both addresses subsequently hit.
//   6. Reset mid-FILL and stats:
//      Assert RST while iREN=1.
//      -> iREN=0 the next cycle; a prior hit address now misses.
//      -> With ICACHE_STATS_EN, after scenario 1 plus 2 hits: miss_count=1, hit_count=3.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking single-word fill.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_e;

  state_e           state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit, fill_done, start_fill;
  logic             unused_byte_bits;

  assign req_idx          = imemaddr[IDX_W+1:2];
  assign req_tag          = imemaddr[31:IDX_W+2];
  assign fill_idx         = miss_addr_q[IDX_W+1:2];
  assign unused_byte_bits = ^imemaddr[1:0];

  assign hit        = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag) && !flush;
  assign fill_done  = (state_q == FILL) && !iwait;
  assign start_fill = (state_q == IDLE) && imemREN && !hit && !flush;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a fill always runs to completion, even across flush or request changes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_fill) state_d = FILL;
      FILL:    if (!iwait)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ihit     = hit;
    imemload = hit ? data_q[req_idx] : 32'h0;
    iREN     = (state_q == FILL);
    iaddr    = (state_q == FILL) ? miss_addr_q : 32'h0;
  end

  // Flush is applied last so it overrides a fill completing on the same edge
  always_comb begin
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    if (fill_done)  valid_d[fill_idx] = 1'b1;
    if (flush)      valid_d = '0;
    if (start_fill) miss_addr_d = {imemaddr[31:2], 2'b00};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= '0;
      miss_addr_q <= '0;
    end else begin
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= miss_addr_q[31:IDX_W+2];
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF))         hit_count_d  = hit_count_q + 32'd1;
    if (start_fill && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: inputs change just after the falling edge,
// combinational outputs are sampled 1 time unit later, state advances on the rising edge.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] D40 = 32'h2001_0005;
  localparam logic [31:0] D80 = 32'hAAAA_0080;
  localparam logic [31:0] D44 = 32'h1234_0044;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .flush(flush)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance one clock, then return just after the falling edge, ready to drive.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // From an IDLE miss cycle: enter FILL, hold iwait for nwait cycles, then deliver data.
  task automatic fill_rest(input int nwait, input logic [31:0] data);
    tick();
    for (int i = 0; i < nwait; i++) begin
      iwait = 1'b1;
      tick();
    end
    iwait = 1'b0; iload = data;
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0; flush = 1'b0;
    tick(); tick();
    RST = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0)      begin n_fail++; $display("FAIL reset_ihit got=%b exp=0", ihit); end
    n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload got=%h exp=0", imemload); end
    n_checks++; if (iREN !== 1'b0)      begin n_fail++; $display("FAIL reset_iREN got=%b exp=0", iREN); end
    n_checks++; if (iaddr !== 32'h0)    begin n_fail++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
  endtask

  task automatic test_cold_miss();
    tick();
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    #1;
    n_checks++; if (ihit !== 1'b0 || iREN !== 1'b0)
      begin n_fail++; $display("FAIL cold_idle ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) begin iwait = 1'b0; iload = D40; end
      #1;
      n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0)
        begin n_fail++; $display("FAIL cold_fill_c%0d iREN=%b iaddr=%h ihit=%b exp 1/40/0", c, iREN, iaddr, ihit); end
    end
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== D40 || iREN !== 1'b0)
      begin n_fail++; $display("FAIL cold_hit ihit=%b imemload=%h iREN=%b exp 1/%h/0", ihit, imemload, iREN, D40); end
  endtask

  task automatic test_hit();
    tick();
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== D40 || iREN !== 1'b0)
      begin n_fail++; $display("FAIL hit_40 ihit=%b imemload=%h iREN=%b exp 1/%h/0", ihit, imemload, iREN, D40); end
    tick();
    imemaddr = 32'h42;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== D40 || iREN !== 1'b0 || iaddr !== 32'h0)
      begin n_fail++; $display("FAIL hit_42 ihit=%b imemload=%h iREN=%b iaddr=%h", ihit, imemload, iREN, iaddr); end
    tick();
    imemREN = 1'b0; imemaddr = 32'h40;
`ifdef ICACHE_STATS_EN
    #1;
    n_checks++; if (miss_count !== 32'd1 || hit_count !== 32'd3)
      begin n_fail++; $display("FAIL stats miss=%0d hit=%0d exp 1/3", miss_count, hit_count); end
`endif
  endtask

  task automatic test_conflict();
    tick();
    imemREN = 1'b1; imemaddr = 32'h80;
    #1;
    n_checks++; if (ihit !== 1'b0 || imemload !== 32'h0)
      begin n_fail++; $display("FAIL conflict_80_miss ihit=%b imemload=%h exp 0/0", ihit, imemload); end
    fill_rest(0, D80);
    n_checks++; if (ihit !== 1'b1 || imemload !== D80)
      begin n_fail++; $display("FAIL conflict_80_hit ihit=%b imemload=%h exp 1/%h", ihit, imemload, D80); end
    tick();
    imemaddr = 32'h40;
    #1;
    n_checks++; if (ihit !== 1'b0)
      begin n_fail++; $display("FAIL conflict_40_evicted ihit=%b exp 0", ihit); end
    fill_rest(2, D40);
    n_checks++; if (ihit !== 1'b1 || imemload !== D40)
      begin n_fail++; $display("FAIL conflict_40_refill ihit=%b imemload=%h exp 1/%h", ihit, imemload, D40); end
  endtask

  task automatic test_flush();
    tick();
    flush = 1'b1;
    #1;
    n_checks++; if (ihit !== 1'b0 || imemload !== 32'h0)
      begin n_fail++; $display("FAIL flush_cycle ihit=%b imemload=%h exp 0/0", ihit, imemload); end
    tick();
    flush = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0 || iREN !== 1'b0)
      begin n_fail++; $display("FAIL flush_after ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    tick();
    iwait = 1'b1;
    #1;
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40)
      begin n_fail++; $display("FAIL flush_refetch iREN=%b iaddr=%h exp 1/40", iREN, iaddr); end
    tick();
    iwait = 1'b0; iload = D40; flush = 1'b1;
    tick();
    iwait = 1'b1; iload = 32'h0; flush = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0 || iREN !== 1'b0)
      begin n_fail++; $display("FAIL flush_on_fill ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    fill_rest(0, D40);
    n_checks++; if (ihit !== 1'b1 || imemload !== D40)
      begin n_fail++; $display("FAIL flush_recover ihit=%b imemload=%h exp 1/%h", ihit, imemload, D40); end
  endtask

  task automatic test_mid_fill();
    tick();
    imemREN = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
    tick();
    imemaddr = 32'h44; iwait = 1'b1;
    #1;
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0)
      begin n_fail++; $display("FAIL midfill_wait iREN=%b iaddr=%h ihit=%b exp 1/40/0", iREN, iaddr, ihit); end
    tick();
    iwait = 1'b0; iload = D40;
    #1;
    n_checks++; if (iaddr !== 32'h40)
      begin n_fail++; $display("FAIL midfill_done iaddr=%h exp 40", iaddr); end
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
    n_checks++; if (ihit !== 1'b0 || iREN !== 1'b0)
      begin n_fail++; $display("FAIL midfill_44_miss ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    tick();
    #1;
    n_checks++; if (iaddr !== 32'h44 || iREN !== 1'b1)
      begin n_fail++; $display("FAIL midfill_44_fetch iaddr=%h iREN=%b exp 44/1", iaddr, iREN); end
    iwait = 1'b0; iload = D44;
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== D44)
      begin n_fail++; $display("FAIL midfill_44_hit ihit=%b imemload=%h exp 1/%h", ihit, imemload, D44); end
    tick();
    imemaddr = 32'h40;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== D40)
      begin n_fail++; $display("FAIL midfill_40_hit ihit=%b imemload=%h exp 1/%h", ihit, imemload, D40); end
  endtask

  task automatic test_reset_mid_fill();
    tick();
    imemaddr = 32'h48;
    tick();
    iwait = 1'b1;
    #1;
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h48)
      begin n_fail++; $display("FAIL rstfill_pre iREN=%b iaddr=%h exp 1/48", iREN, iaddr); end
    RST = 1'b1;
    tick();
    RST = 1'b0; imemaddr = 32'h40;
    #1;
    n_checks++; if (iREN !== 1'b0 || iaddr !== 32'h0)
      begin n_fail++; $display("FAIL rstfill_iREN iREN=%b iaddr=%h exp 0/0", iREN, iaddr); end
    n_checks++; if (ihit !== 1'b0 || imemload !== 32'h0)
      begin n_fail++; $display("FAIL rstfill_40_miss ihit=%b imemload=%h exp 0/0", ihit, imemload); end
`ifdef ICACHE_STATS_EN
    n_checks++; if (miss_count !== 32'd0 || hit_count !== 32'd0)
      begin n_fail++; $display("FAIL rstfill_stats miss=%0d hit=%0d exp 0/0", miss_count, hit_count); end
`endif
    imemREN = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_mid_fill();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
